// File: rtl/tank2_sprite_fetch.sv
// Tank-2 sprite fetch stage: turns the raster position into a rotated sprite-ROM
// address, then aligns the ROM word with an in-box flag to produce a palette index
// plus an opaque flag. Latency from raster position to pix_* is a fixed 3 cycles.
// The block also latches the tank position once per frame and runs the damage flash.
module tank2_sprite_fetch #(
  parameter int unsigned SPRITE_SIZE  = 32,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned TRANSP_INDEX = 0,
  parameter int unsigned FLASH_INDEX  = 6,
  parameter int unsigned FLASH_FRAMES = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        tank_x,
  input  logic [9:0]        tank_y,
  input  logic [1:0]        tank_dir,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              pix_opaque,
  output logic              flashing
);

  localparam int unsigned LogS        = $clog2(SPRITE_SIZE);
  localparam logic [10:0] SizeW       = 11'(SPRITE_SIZE);
  localparam logic [3:0]  TranspIdx   = 4'(TRANSP_INDEX);
  localparam logic [3:0]  FlashIdx    = 4'(FLASH_INDEX);
  localparam logic [5:0]  FlashReload = 6'(FLASH_FRAMES);

  // Per-frame position latch
  logic [9:0] lx_q, lx_d;
  logic [9:0] ly_q, ly_d;
  logic [1:0] ldir_q, ldir_d;

  // Pipeline state
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              in_d1_q, in_d1_d;
  logic              in_d2_q, in_d2_d;
  logic [3:0]        pix_index_q, pix_index_d;
  logic              pix_opaque_q, pix_opaque_d;

  // Flash state
  logic [5:0] fc_q, fc_d;
  logic       flashing_q, flashing_d;

  // Stage-0 intermediates
  logic [10:0]     dx, dy;
  logic            in_box;
  logic [LogS-1:0] dx_s, dy_s, u, v;

  // Stage-2 intermediates
  logic opq, flash_on;

  // Capture tank pose only at frame start so a frame is never torn
  always_comb begin
    lx_d   = lx_q;
    ly_d   = ly_q;
    ldir_d = ldir_q;
    if (frame_start) begin
      lx_d   = tank_x;
      ly_d   = tank_y;
      ldir_d = tank_dir;
    end
  end

  // Stage 0: box test and rotated ROM address
  always_comb begin
    // 11-bit unsigned differences; the DrawX >= lx test rejects wrapped values,
    // so a sprite near the right/bottom edge is clipped rather than wrapped.
    dx     = {1'b0, DrawX} - {1'b0, lx_q};
    dy     = {1'b0, DrawY} - {1'b0, ly_q};
    in_box = (DrawX >= lx_q) && (dx < SizeW) && (DrawY >= ly_q) && (dy < SizeW);
    dx_s   = dx[LogS-1:0];
    dy_s   = dy[LogS-1:0];
    u      = dx_s;
    v      = dy_s;
    // S-1-n within LogS bits is just the bitwise complement
    unique case (ldir_q)
      2'd0: begin u = dx_s;  v = dy_s;  end
      2'd1: begin u = dy_s;  v = ~dx_s; end
      2'd2: begin u = ~dx_s; v = ~dy_s; end
      2'd3: begin u = ~dy_s; v = dx_s;  end
      default: begin u = dx_s; v = dy_s; end
    endcase
    rom_addr_d = ADDR_W'({v, u});
    in_d1_d    = in_box;
    in_d2_d    = in_d1_q;
  end

  // Flash counter: a hit reloads and beats a same-cycle frame decrement
  always_comb begin
    fc_d = fc_q;
    if (hit) begin
      fc_d = FlashReload;
    end else if (frame_start && (fc_q != 6'd0)) begin
      fc_d = fc_q - 6'd1;
    end
    // Derived from fc_d so flashing lines up with the counter register
    flashing_d = (fc_d != 6'd0);
  end

  // Stage 2: transparency and flash substitution on the returned ROM word
  always_comb begin
    opq          = in_d2_q && (rom_q != TranspIdx);
    flash_on     = (fc_q != 6'd0) && fc_q[2];
    pix_opaque_d = opq;
    pix_index_d  = 4'd0;
    if (opq) begin
      pix_index_d = flash_on ? FlashIdx : rom_q;
    end
  end

  // All state registers with synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lx_q         <= '0;
      ly_q         <= '0;
      ldir_q       <= '0;
      rom_addr_q   <= '0;
      in_d1_q      <= 1'b0;
      in_d2_q      <= 1'b0;
      pix_index_q  <= '0;
      pix_opaque_q <= 1'b0;
      fc_q         <= '0;
      flashing_q   <= 1'b0;
    end else begin
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      ldir_q       <= ldir_d;
      rom_addr_q   <= rom_addr_d;
      in_d1_q      <= in_d1_d;
      in_d2_q      <= in_d2_d;
      pix_index_q  <= pix_index_d;
      pix_opaque_q <= pix_opaque_d;
      fc_q         <= fc_d;
      flashing_q   <= flashing_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_index  = pix_index_q;
  assign pix_opaque = pix_opaque_q;
  assign flashing   = flashing_q;

endmodule

// File: tb/tb_tank2_sprite_fetch.sv
// Directed bench for tank2_sprite_fetch with a synchronous ROM model.
// ROM word at address a is a[3:0] ^ 4'hA, so addresses ending in 0xA are transparent.
module tb_tank2_sprite_fetch;

  logic       Clk;
  logic       Reset;
  logic       frame_start;
  logic [9:0] DrawX, DrawY, tank_x, tank_y;
  logic [1:0] tank_dir;
  logic       hit;
  logic [9:0] rom_addr;
  logic [3:0] rom_q;
  logic [3:0] pix_index;
  logic       pix_opaque;
  logic       flashing;

  int n_pass  = 0;
  int n_total = 0;

  tank2_sprite_fetch #(
    .SPRITE_SIZE (32),
    .ADDR_W      (10),
    .TRANSP_INDEX(0),
    .FLASH_INDEX (6),
    .FLASH_FRAMES(32)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .tank_x     (tank_x),
    .tank_y     (tank_y),
    .tank_dir   (tank_dir),
    .hit        (hit),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pix_index  (pix_index),
    .pix_opaque (pix_opaque),
    .flashing   (flashing)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous sprite ROM
  always @(posedge Clk) begin
    rom_q <= rom_addr[3:0] ^ 4'hA;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // All tasks enter and leave at a falling edge
  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
    frame_start = 1'b1;
    tank_x      = x;
    tank_y      = y;
    tank_dir    = d;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_hit(input logic with_frame);
    hit         = 1'b1;
    frame_start = with_frame;
    @(negedge Clk);
    hit         = 1'b0;
    frame_start = 1'b0;
  endtask

  // Hold a raster position for 3 cycles; optionally check the address at t+1
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic chk_addr, input logic [9:0] exp_addr,
                     input logic exp_opq, input logic [3:0] exp_idx);
    DrawX = x;
    DrawY = y;
    @(negedge Clk);
    if (chk_addr) check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    @(negedge Clk);
    @(negedge Clk);
    check({tag, ".opq"}, 32'(pix_opaque), 32'(exp_opq));
    check({tag, ".idx"}, 32'(pix_index), 32'(exp_idx));
  endtask

  initial begin
    Reset       = 1'b1;
    frame_start = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    tank_x      = '0;
    tank_y      = '0;
    tank_dir    = '0;
    hit         = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst.addr", 32'(rom_addr), 32'd0);
    check("rst.opq", 32'(pix_opaque), 32'd0);
    check("rst.idx", 32'(pix_index), 32'd0);
    check("rst.flash", 32'(flashing), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // T1/T2: dir 0 at (100,200)
    frame(10'd100, 10'd200, 2'd0);
    pix("t1.origin", 10'd100, 10'd200, 1'b1, 10'd0, 1'b1, 4'hA);
    pix("t2.corner", 10'd131, 10'd231, 1'b1, 10'd1023, 1'b1, 4'h5);
    pix("t2.right", 10'd132, 10'd231, 1'b0, 10'd0, 1'b0, 4'h0);
    pix("t2.left", 10'd99, 10'd200, 1'b0, 10'd0, 1'b0, 4'h0);
    pix("t2.below", 10'd100, 10'd232, 1'b0, 10'd0, 1'b0, 4'h0);

    // T3: rotations at dx=5, dy=0
    frame(10'd100, 10'd200, 2'd1);
    pix("t3.dir1", 10'd105, 10'd200, 1'b1, 10'd832, 1'b1, 4'hA);
    frame(10'd100, 10'd200, 2'd2);
    pix("t3.dir2", 10'd105, 10'd200, 1'b1, 10'd1018, 1'b0, 4'h0);
    frame(10'd100, 10'd200, 2'd3);
    pix("t3.dir3", 10'd105, 10'd200, 1'b1, 10'd191, 1'b1, 4'h5);

    // T4: right-edge clipping, no wrap to column 0
    frame(10'd620, 10'd200, 2'd0);
    pix("t4.edge", 10'd639, 10'd200, 1'b1, 10'd19, 1'b1, 4'h9);
    for (int x = 0; x < 12; x++) begin
      pix("t4.nowrap", 10'(x), 10'd200, 1'b0, 10'd0, 1'b0, 4'h0);
    end

    // T5: transparent word, and mid-frame pose changes ignored
    frame(10'd100, 10'd200, 2'd0);
    pix("t5.transp", 10'd110, 10'd200, 1'b1, 10'd10, 1'b0, 4'h0);
    tank_x   = 10'd300;
    tank_dir = 2'd1;
    pix("t5.midframe", 10'd100, 10'd200, 1'b1, 10'd0, 1'b1, 4'hA);
    tank_x   = 10'd100;
    tank_dir = 2'd0;

    // T6: flash counter (pixel at addr 1 normally reads 0xB)
    pulse_hit(1'b0);
    check("t6.hit.flashing", 32'(flashing), 32'd1);
    pix("t6.fc32", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'hB);
    frame(10'd100, 10'd200, 2'd0);
    pix("t6.fc31", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'h6);
    frame(10'd100, 10'd200, 2'd0);
    pulse_hit(1'b0);
    pix("t6.restart", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'hB);
    frame(10'd100, 10'd200, 2'd0);
    pix("t6.fc31b", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'h6);
    pix("t6.transp", 10'd110, 10'd200, 1'b0, 10'd0, 1'b0, 4'h0);
    repeat (4) frame(10'd100, 10'd200, 2'd0);
    pix("t6.fc27", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'hB);
    repeat (26) frame(10'd100, 10'd200, 2'd0);
    check("t6.fc1.flashing", 32'(flashing), 32'd1);
    frame(10'd100, 10'd200, 2'd0);
    check("t6.fc0.flashing", 32'(flashing), 32'd0);
    pix("t6.done", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'hB);
    pulse_hit(1'b1);
    check("t6.coinc.flashing", 32'(flashing), 32'd1);
    pix("t6.coinc32", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'hB);
    frame(10'd100, 10'd200, 2'd0);
    pix("t6.coinc31", 10'd101, 10'd200, 1'b0, 10'd0, 1'b1, 4'h6);

    // Mid-frame reset: outputs clear, latch returns to 0
    DrawX = 10'd100;
    DrawY = 10'd200;
    repeat (3) @(negedge Clk);
    check("rst2.pre", 32'(pix_opaque), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rst2.opq", 32'(pix_opaque), 32'd0);
    check("rst2.idx", 32'(pix_index), 32'd0);
    check("rst2.addr", 32'(rom_addr), 32'd0);
    check("rst2.flash", 32'(flashing), 32'd0);
    pix("rst2.latch0", 10'd5, 10'd5, 1'b1, 10'd165, 1'b1, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
